bullet_controller: RTL and testbench
====================================

# bullet_controller

Single-bullet motion engine for one tank's bullet slot. Launches a bullet from the tank's muzzle on a fire-button press, advances it once per video frame, bounces it off the arena edges, and retires it on lifetime expiry or tank-bullet collision. Its position/active outputs feed the tank-bullet collision checker, whose collision flag is fed back as TBCollided. Multiple instances provide multiple bullet slots.

## Interface
- BULLET_SPEED, 2: pixels per frame per axis component (1..15).
- SPAWN_OFFSET, 12: muzzle distance from tank centre, per axis component.
- LIFETIME, 600: number of frame moves before expiry (≤ 4095).
- COOLDOWN, 30: frames after retirement before re-arming (≤ 255).
- X_MIN, 0 / X_MAX, 639 / Y_MIN, 0 / Y_MAX, 479: arena bounds, inclusive.
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- frame_clk  in  1  frame strobe, synchronous to Clk; its rising edge is one frame tick.
- fire  in  1  fire button, level; only its 0→1 edge launches.
- Tank_X_Pos, Tank_Y_Pos  in  10  tank centre.
- Tank_Dir  in  3  facing: 0 up, 1 up-right, 2 right, 3 down-right, 4 down, 5 down-left, 6 left, 7 up-left.
- TBCollided  in  1  collision flag from the collision checker.
- Bullet_X_Pos, Bullet_Y_Pos  out  10  bullet position.
- isBulletActive  out  1  bullet in flight.
- fire_ack  out  1  one-cycle pulse on launch.

## Operation
- States: IDLE, ACTIVE, COOLDOWN. Reset → IDLE. All outputs 0; vx = vy = 0; counters 0; frame_prev = 0; fire_prev = 1, so a button held through reset does not fire.
- Edges: fire_edge = fire & ~fire_prev; tick = frame_clk & ~frame_prev. Both prev registers update every cycle.
- IDLE + fire_edge: latch the direction unit vector (dx, dy ∈ {−1, 0, +1}) from Tank_Dir. Set vx = dx·BULLET_SPEED and vy = dy·BULLET_SPEED. Load position = Tank_Pos + d·SPAWN_OFFSET per axis, clamped to [MIN, MAX]. Set life_cnt = LIFETIME, assert fire_ack, → ACTIVE. A fire_edge in ACTIVE or COOLDOWN is discarded; there is no queue.
- ACTIVE, priority order:
  1. TBCollided = 1 → COOLDOWN.
  2. tick with life_cnt = 0 → COOLDOWN.
  3. tick otherwise → move and decrement life_cnt.
- Move, per axis, in 12-bit signed: n = pos + v.
  - n > MAX → pos = 2·MAX − n, v = −v.
  - n < MIN → pos = 2·MIN − n, v = −v.
  - Otherwise pos = n.
  - Axes are independent; a corner hit reflects both axes on the same tick.
- Entering COOLDOWN: cd_cnt = COOLDOWN; isBulletActive = 0; position outputs hold their last value.
- COOLDOWN: cd_cnt = 0 → IDLE on the next cycle, with no tick needed. Otherwise each tick decrements cd_cnt. TBCollided is ignored.
- IDLE and COOLDOWN ignore TBCollided and ticks, except the COOLDOWN counter.
- Reset mid-flight: immediate return to reset values; no fire_ack.

## Timing
- All outputs are registered.
- fire 0→1 sampled at Clk edge N: isBulletActive = 1, spawn position valid, fire_ack = 1 from edge N+1. fire_ack is 1 for exactly one cycle.
- frame_clk rise sampled at edge M: updated position visible after edge M+1. One move per frame_clk rising edge, regardless of how long frame_clk stays high.
- TBCollided sampled high at edge K: isBulletActive = 0 after edge K+1. This holds even if a tick coincides; the position does not move on that tick.
- Expiry: exactly LIFETIME moves; isBulletActive falls one cycle after tick LIFETIME+1.
- Re-arm: IDLE is reached one cycle after the COOLDOWN-th tick following retirement. With COOLDOWN = 0, IDLE is reached 2 cycles after retirement.
- A fire_edge arriving in the same cycle as the COOLDOWN→IDLE transition is discarded.

## Test plan
- Launch right: Tank (100,200), Dir 2, defaults, fire pulse → fire_ack one cycle, position (112,200), active = 1. After 3 ticks → (118,200).
- Right-wall bounce: Dir 2 from tank X 626 → spawn X 638. Tick 1 → X 638 with vx = −2; tick 2 → 636. Diagonal Dir 1 from tank (626,13) → spawn (638,1); tick 1 → (638,1) with both velocities reflected; tick 2 → (636,3).
- Collision with coincident tick while ACTIVE at (300,300), Dir 4: TBCollided = 1 and frame_clk rise in the same cycle → active = 0 next cycle, position stays (300,300). A fire pulse 5 cycles later is ignored (COOLDOWN = 30). After 30 ticks plus 1 cycle, a fire pulse launches again.
- Lifetime with LIFETIME = 4, COOLDOWN = 0: 4 ticks each move the bullet by 2; the 5th tick drops active with no move. IDLE is reached 2 cycles later, and a new fire launches.
- Reset behaviour: fire held high across Reset deassertion → no launch. Release then press → launch. Assert Reset mid-flight → all outputs 0 immediately; after deassertion, ticks do not move the bullet.
- Edge-only triggers: fire held high for 100 cycles → exactly one fire_ack. frame_clk held high for 50 cycles → exactly one move.

Source files
------------

// File: rtl/bullet_controller.sv
// bullet_controller
//   Motion engine for a single bullet slot of one tank. A rising edge on the
//   fire button launches a bullet from the tank's muzzle. The bullet moves
//   once per frame strobe and reflects off the arena edges. It retires when
//   its move budget runs out or when the collision checker flags a hit.
//   After retirement the slot waits out a re-arm cooldown before it can fire
//   again.
//
// Ports
//   Clk, Reset                 system clock, asynchronous active-high reset
//   frame_clk                  frame strobe (rising edge = one frame tick)
//   fire                       fire button level (0->1 edge launches)
//   Tank_X_Pos, Tank_Y_Pos     tank centre
//   Tank_Dir                   facing, 0 = up, clockwise in 45-degree steps
//   TBCollided                 tank-bullet collision flag
//   Bullet_X_Pos, Bullet_Y_Pos bullet position (registered)
//   isBulletActive             bullet in flight (registered)
//   fire_ack                   one-cycle launch pulse (registered)
module bullet_controller #(
  parameter int BULLET_SPEED = 2,
  parameter int SPAWN_OFFSET = 12,
  parameter int LIFETIME     = 600,
  parameter int COOLDOWN     = 30,
  parameter int X_MIN        = 0,
  parameter int X_MAX        = 639,
  parameter int Y_MIN        = 0,
  parameter int Y_MAX        = 479
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       fire,
  input  logic [9:0] Tank_X_Pos,
  input  logic [9:0] Tank_Y_Pos,
  input  logic [2:0] Tank_Dir,
  input  logic       TBCollided,
  output logic [9:0] Bullet_X_Pos,
  output logic [9:0] Bullet_Y_Pos,
  output logic       isBulletActive,
  output logic       fire_ack
);

  localparam logic signed [11:0] SPD  = 12'(BULLET_SPEED);
  localparam logic signed [11:0] OFF  = 12'(SPAWN_OFFSET);
  localparam logic signed [11:0] XLO  = 12'(X_MIN);
  localparam logic signed [11:0] XHI  = 12'(X_MAX);
  localparam logic signed [11:0] YLO  = 12'(Y_MIN);
  localparam logic signed [11:0] YHI  = 12'(Y_MAX);
  localparam logic [11:0]        LIFE = 12'(LIFETIME);
  localparam logic [7:0]         CD   = 8'(COOLDOWN);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_COOLDOWN} state_t;

  typedef struct packed {
    logic [9:0]        pos;
    logic signed [11:0] vel;
  } axis_t;

  // Unit direction: {dx, dy}, each 2-bit signed. Screen y grows downward.
  function automatic logic [3:0] dir_unit(input logic [2:0] d);
    case (d)
      3'd0:    return {2'b00, 2'b11};
      3'd1:    return {2'b01, 2'b11};
      3'd2:    return {2'b01, 2'b00};
      3'd3:    return {2'b01, 2'b01};
      3'd4:    return {2'b00, 2'b01};
      3'd5:    return {2'b11, 2'b01};
      3'd6:    return {2'b11, 2'b00};
      default: return {2'b11, 2'b11};
    endcase
  endfunction

  function automatic logic signed [11:0] scale(input logic [1:0] d,
                                               input logic signed [11:0] mag);
    case (d)
      2'b01:   return mag;
      2'b11:   return -mag;
      default: return '0;
    endcase
  endfunction

  // Muzzle position: tank centre plus offset, pinned inside the arena.
  function automatic logic [9:0] spawn(input logic [9:0] c,
                                       input logic signed [11:0] off,
                                       input logic signed [11:0] lo,
                                       input logic signed [11:0] hi);
    logic signed [11:0] n;
    n = $signed({2'b00, c}) + off;
    if (n > hi)      n = hi;
    else if (n < lo) n = lo;
    return n[9:0];
  endfunction

  // One frame step on one axis; an overshoot past a wall is mirrored back
  // inside and the velocity sign flips.
  function automatic axis_t move_axis(input logic [9:0] pos,
                                      input logic signed [11:0] vel,
                                      input logic signed [11:0] lo,
                                      input logic signed [11:0] hi);
    logic signed [11:0] n;
    axis_t r;
    n = $signed({2'b00, pos}) + vel;
    r.vel = vel;
    if (n > hi) begin
      n = (hi <<< 1) - n;
      r.vel = -vel;
    end else if (n < lo) begin
      n = (lo <<< 1) - n;
      r.vel = -vel;
    end
    r.pos = n[9:0];
    return r;
  endfunction

  state_t             state, state_n;
  logic [9:0]         pos_x, pos_x_n, pos_y, pos_y_n;
  logic signed [11:0] vel_x, vel_x_n, vel_y, vel_y_n;
  logic [11:0]        life_cnt, life_cnt_n;
  logic [7:0]         cd_cnt, cd_cnt_n;
  logic               frame_prev, fire_prev;
  logic               active, active_n, ack, ack_n;
  logic               fire_edge, tick;
  logic [3:0]         unit;
  axis_t              mx, my;

  // Registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= S_IDLE;
      pos_x      <= '0;
      pos_y      <= '0;
      vel_x      <= '0;
      vel_y      <= '0;
      life_cnt   <= '0;
      cd_cnt     <= '0;
      frame_prev <= 1'b0;
      // Treat the button as already held so a press spanning reset is inert.
      fire_prev  <= 1'b1;
      active     <= 1'b0;
      ack        <= 1'b0;
    end else begin
      state      <= state_n;
      pos_x      <= pos_x_n;
      pos_y      <= pos_y_n;
      vel_x      <= vel_x_n;
      vel_y      <= vel_y_n;
      life_cnt   <= life_cnt_n;
      cd_cnt     <= cd_cnt_n;
      frame_prev <= frame_clk;
      fire_prev  <= fire;
      active     <= active_n;
      ack        <= ack_n;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_n    = state;
    pos_x_n    = pos_x;
    pos_y_n    = pos_y;
    vel_x_n    = vel_x;
    vel_y_n    = vel_y;
    life_cnt_n = life_cnt;
    cd_cnt_n   = cd_cnt;
    active_n   = active;
    ack_n      = 1'b0;
    fire_edge  = fire & ~fire_prev;
    tick       = frame_clk & ~frame_prev;
    unit       = dir_unit(Tank_Dir);
    mx         = move_axis(pos_x, vel_x, XLO, XHI);
    my         = move_axis(pos_y, vel_y, YLO, YHI);

    case (state)
      S_IDLE: begin
        if (fire_edge) begin
          vel_x_n    = scale(unit[3:2], SPD);
          vel_y_n    = scale(unit[1:0], SPD);
          pos_x_n    = spawn(Tank_X_Pos, scale(unit[3:2], OFF), XLO, XHI);
          pos_y_n    = spawn(Tank_Y_Pos, scale(unit[1:0], OFF), YLO, YHI);
          life_cnt_n = LIFE;
          active_n   = 1'b1;
          ack_n      = 1'b1;
          state_n    = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        // A hit wins over a coincident tick, so the bullet freezes in place.
        if (TBCollided || (tick && life_cnt == 12'd0)) begin
          cd_cnt_n = CD;
          active_n = 1'b0;
          state_n  = S_COOLDOWN;
        end else if (tick) begin
          pos_x_n    = mx.pos;
          vel_x_n    = mx.vel;
          pos_y_n    = my.pos;
          vel_y_n    = my.vel;
          life_cnt_n = life_cnt - 12'd1;
        end
      end
      S_COOLDOWN: begin
        if (cd_cnt == 8'd0) state_n = S_IDLE;
        else if (tick)      cd_cnt_n = cd_cnt - 8'd1;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign Bullet_X_Pos   = pos_x;
  assign Bullet_Y_Pos   = pos_y;
  assign isBulletActive = active;
  assign fire_ack       = ack;

endmodule

// File: tb/tb_bullet_controller.sv
module tb_bullet_controller;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       frame_clk;
  logic       fire;
  logic [9:0] tank_x, tank_y;
  logic [2:0] dir;
  logic       tbc;

  logic [9:0] ax, ay, bx, by;
  logic       a_act, a_ack, b_act, b_ack;

  // Instance A: default parameters. Instance B: short lifetime, no cooldown.
  bullet_controller dut_a (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .fire(fire),
    .Tank_X_Pos(tank_x), .Tank_Y_Pos(tank_y), .Tank_Dir(dir),
    .TBCollided(tbc),
    .Bullet_X_Pos(ax), .Bullet_Y_Pos(ay),
    .isBulletActive(a_act), .fire_ack(a_ack)
  );

  bullet_controller #(.LIFETIME(4), .COOLDOWN(0)) dut_b (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .fire(fire),
    .Tank_X_Pos(tank_x), .Tank_Y_Pos(tank_y), .Tank_Dir(dir),
    .TBCollided(tbc),
    .Bullet_X_Pos(bx), .Bullet_Y_Pos(by),
    .isBulletActive(b_act), .fire_ack(b_ack)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    bit         sel;
    logic [9:0] x;
    logic [9:0] y;
    logic       act;
    logic       ack;
  } exp_t;

  exp_t  sb[$];
  string tags[$];
  int    vectors = 0;
  int    miscompares = 0;

  task automatic expect_out(input string tag, input bit sel, input int x,
                            input int y, input logic act, input logic ack);
    exp_t e;
    e.sel = sel;
    e.x   = 10'(x);
    e.y   = 10'(y);
    e.act = act;
    e.ack = ack;
    sb.push_back(e);
    tags.push_back(tag);
  endtask

  task automatic compare_pending();
    exp_t       e;
    string      t;
    logic [9:0] ox, oy;
    logic       oa, ok;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      t = tags.pop_front();
      if (e.sel) begin
        ox = bx; oy = by; oa = b_act; ok = b_ack;
      end else begin
        ox = ax; oy = ay; oa = a_act; ok = a_ack;
      end
      vectors++;
      assert ({ox, oy, oa, ok} === {e.x, e.y, e.act, e.ack}) else begin
        miscompares++;
        $error("FAIL %s: observed x=%0d y=%0d act=%b ack=%b, expected x=%0d y=%0d act=%b ack=%b",
               t, ox, oy, oa, ok, e.x, e.y, e.act, e.ack);
      end
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
    compare_pending();
  endtask

  // One frame strobe: a rising cycle and a falling cycle, outputs expected
  // to hold the same value through both.
  task automatic frame_tick(input string tag, input bit sel, input int x,
                            input int y, input logic act);
    frame_clk = 1'b1;
    expect_out(tag, sel, x, y, act, 1'b0);
    cyc();
    frame_clk = 1'b0;
    expect_out(tag, sel, x, y, act, 1'b0);
    cyc();
  endtask

  task automatic do_reset();
    Reset = 1'b1; fire = 1'b0; frame_clk = 1'b0; tbc = 1'b0;
    expect_out("reset_a", 1'b0, 0, 0, 1'b0, 1'b0);
    expect_out("reset_b", 1'b1, 0, 0, 1'b0, 1'b0);
    cyc();
    Reset = 1'b0;
    expect_out("post_reset_a", 1'b0, 0, 0, 1'b0, 1'b0);
    cyc();
  endtask

  initial begin
    int acks;
    Reset = 1'b1; fire = 1'b0; frame_clk = 1'b0; tbc = 1'b0;
    tank_x = 10'd0; tank_y = 10'd0; dir = 3'd0;
    cyc();

    // Launch right from (100,200)
    do_reset();
    tank_x = 10'd100; tank_y = 10'd200; dir = 3'd2;
    fire = 1'b1;
    expect_out("launch", 1'b0, 112, 200, 1'b1, 1'b1);
    cyc();
    fire = 1'b0;
    expect_out("launch_ack_drop", 1'b0, 112, 200, 1'b1, 1'b0);
    cyc();
    frame_tick("move1", 1'b0, 114, 200, 1'b1);
    frame_tick("move2", 1'b0, 116, 200, 1'b1);
    frame_tick("move3", 1'b0, 118, 200, 1'b1);

    // Right-wall bounce
    do_reset();
    tank_x = 10'd626; tank_y = 10'd200; dir = 3'd2;
    fire = 1'b1;
    expect_out("wall_spawn", 1'b0, 638, 200, 1'b1, 1'b1);
    cyc();
    fire = 1'b0;
    cyc();
    frame_tick("wall_t1", 1'b0, 638, 200, 1'b1);
    frame_tick("wall_t2", 1'b0, 636, 200, 1'b1);
    frame_tick("wall_t3", 1'b0, 634, 200, 1'b1);

    // Corner bounce, both axes on the same tick
    do_reset();
    tank_x = 10'd626; tank_y = 10'd13; dir = 3'd1;
    fire = 1'b1;
    expect_out("corner_spawn", 1'b0, 638, 1, 1'b1, 1'b1);
    cyc();
    fire = 1'b0;
    cyc();
    frame_tick("corner_t1", 1'b0, 638, 1, 1'b1);
    frame_tick("corner_t2", 1'b0, 636, 3, 1'b1);

    // Spawn clamp at the top edge
    do_reset();
    tank_x = 10'd50; tank_y = 10'd5; dir = 3'd0;
    fire = 1'b1;
    expect_out("clamp_spawn", 1'b0, 50, 0, 1'b1, 1'b1);
    cyc();
    fire = 1'b0;
    cyc();

    // Collision coincident with a tick, then cooldown
    do_reset();
    tank_x = 10'd300; tank_y = 10'd288; dir = 3'd4;
    fire = 1'b1;
    expect_out("coll_spawn", 1'b0, 300, 300, 1'b1, 1'b1);
    cyc();
    fire = 1'b0;
    expect_out("coll_pre", 1'b0, 300, 300, 1'b1, 1'b0);
    cyc();
    tbc = 1'b1; frame_clk = 1'b1;
    expect_out("coll_hit", 1'b0, 300, 300, 1'b0, 1'b0);
    cyc();
    tbc = 1'b0; frame_clk = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    fire = 1'b1;
    expect_out("coll_fire_ignored", 1'b0, 300, 300, 1'b0, 1'b0);
    cyc();
    fire = 1'b0;
    cyc();
    for (int i = 0; i < 29; i++) frame_tick("cooldown", 1'b0, 300, 300, 1'b0);
    fire = 1'b1;
    expect_out("cooldown_29_fire_ignored", 1'b0, 300, 300, 1'b0, 1'b0);
    cyc();
    fire = 1'b0;
    cyc();
    frame_tick("cooldown_30", 1'b0, 300, 300, 1'b0);
    fire = 1'b1;
    expect_out("rearm_launch", 1'b0, 300, 300, 1'b1, 1'b1);
    cyc();
    fire = 1'b0;
    cyc();

    // Lifetime expiry on instance B (LIFETIME=4, COOLDOWN=0)
    do_reset();
    tank_x = 10'd100; tank_y = 10'd200; dir = 3'd2;
    fire = 1'b1;
    expect_out("life_spawn", 1'b1, 112, 200, 1'b1, 1'b1);
    cyc();
    fire = 1'b0;
    expect_out("life_ack_drop", 1'b1, 112, 200, 1'b1, 1'b0);
    cyc();
    frame_tick("life_m1", 1'b1, 114, 200, 1'b1);
    frame_tick("life_m2", 1'b1, 116, 200, 1'b1);
    frame_tick("life_m3", 1'b1, 118, 200, 1'b1);
    frame_tick("life_m4", 1'b1, 120, 200, 1'b1);
    frame_clk = 1'b1;
    expect_out("life_expire", 1'b1, 120, 200, 1'b0, 1'b0);
    cyc();
    // Fire edge on the COOLDOWN->IDLE cycle is dropped
    frame_clk = 1'b0; fire = 1'b1;
    expect_out("life_transition_fire", 1'b1, 120, 200, 1'b0, 1'b0);
    cyc();
    fire = 1'b0;
    expect_out("life_idle", 1'b1, 120, 200, 1'b0, 1'b0);
    cyc();
    fire = 1'b1;
    expect_out("life_relaunch", 1'b1, 112, 200, 1'b1, 1'b1);
    cyc();
    fire = 1'b0;
    cyc();

    // Fire held across reset deassertion
    Reset = 1'b1; fire = 1'b1;
    expect_out("held_reset", 1'b0, 0, 0, 1'b0, 1'b0);
    cyc();
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      expect_out("held_no_launch", 1'b0, 0, 0, 1'b0, 1'b0);
      cyc();
    end
    fire = 1'b0;
    cyc();
    fire = 1'b1;
    expect_out("press_after_release", 1'b0, 112, 200, 1'b1, 1'b1);
    cyc();
    fire = 1'b0;
    cyc();
    // Asynchronous reset mid-flight
    Reset = 1'b1;
    #1;
    expect_out("async_reset", 1'b0, 0, 0, 1'b0, 1'b0);
    compare_pending();
    cyc();
    Reset = 1'b0;
    cyc();
    frame_tick("reset_no_move1", 1'b0, 0, 0, 1'b0);
    frame_tick("reset_no_move2", 1'b0, 0, 0, 1'b0);

    // Edge-only triggers
    do_reset();
    tank_x = 10'd100; tank_y = 10'd200; dir = 3'd2;
    fire = 1'b1;
    acks = 0;
    for (int i = 0; i < 100; i++) begin
      cyc();
      acks += int'(a_ack);
    end
    check_int("fire_hold_acks", acks, 1);
    fire = 1'b0;
    expect_out("fire_hold_pos", 1'b0, 112, 200, 1'b1, 1'b0);
    cyc();
    frame_clk = 1'b1;
    for (int i = 0; i < 50; i++) cyc();
    frame_clk = 1'b0;
    expect_out("frame_hold_one_move", 1'b0, 114, 200, 1'b1, 1'b0);
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
